// File: rtl/sum_stream_arbiter_if.sv
// Handshake bundle between R AXI-Stream requesters, the arbiter and the
// downstream summing engine. The master modport is the arbiter's view.
interface sum_stream_arbiter_if #(
  parameter int W = 16,
  parameter int R = 2
);
  localparam int IW = ($clog2(R) > 1) ? $clog2(R) : 1;

  logic [R-1:0]   s_valid;
  logic [R-1:0]   s_ready;
  logic [R*W-1:0] s_data;
  logic           m_valid;
  logic           m_ready;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic [IW-1:0]  m_id;
  logic           pkt_done;
  logic           busy;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last, m_id, pkt_done, busy
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_id, pkt_done, busy
  );
endinterface

// File: rtl/sum_stream_arbiter.sv
// Round-robin, packet-locked arbiter: one requester owns the summing engine
// for exactly N accepted beats, then priority rotates past it.
module sum_stream_arbiter #(
  parameter int W = 16,
  parameter int N = 3,
  parameter int R = 2
) (
  input logic                 clk,
  input logic                 rst,
  sum_stream_arbiter_if.master bus
);
  localparam int IW = ($clog2(R) > 1) ? $clog2(R) : 1;
  localparam int CW = ($clog2(N) > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state_r;
  logic [IW-1:0] gnt_r;
  logic [IW-1:0] last_gnt_r;
  logic [CW-1:0] beat_cnt_r;
  logic          pkt_done_r;

  logic [IW-1:0] next_gnt_s;
  logic [IW-1:0] cand_s;
  logic          found_s;
  int            idx_s;
  logic          accept_s;
  logic          last_beat_s;
  logic [W-1:0]  data_arr_s [R];

  for (genvar i = 0; i < R; i++) begin : g_unpack
    assign data_arr_s[i] = bus.s_data[i*W +: W];
  end

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    next_gnt_s = gnt_r;
    found_s    = 1'b0;
    idx_s      = 0;
    cand_s     = '0;
    for (int i = 1; i <= R; i++) begin
      idx_s  = (int'(last_gnt_r) + i) % R;
      cand_s = IW'(idx_s);
      if (!found_s && bus.s_valid[cand_s]) begin
        found_s    = 1'b1;
        next_gnt_s = cand_s;
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Zero-latency pass-through of the granted requester while BUSY.
  always_comb begin
    bus.s_ready = '0;
    bus.m_valid = 1'b0;
    bus.m_data  = '0;
    bus.m_last  = 1'b0;
    bus.m_id    = '0;
    bus.busy    = 1'b0;
    if (state_r == ST_BUSY) begin
      bus.m_valid        = bus.s_valid[gnt_r];
      bus.m_data         = data_arr_s[gnt_r];
      bus.s_ready[gnt_r] = bus.m_ready;
      bus.m_last         = (beat_cnt_r == CW'(N - 1));
      bus.m_id           = gnt_r;
      bus.busy           = 1'b1;
    end else begin
      bus.busy           = 1'b0;
    end
  end

  assign accept_s     = bus.m_valid && bus.m_ready;
  assign last_beat_s  = accept_s && bus.m_last;
  assign bus.pkt_done = pkt_done_r;

  // Grant/beat-count state; reset abandons any packet and restores requester 0 priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      gnt_r      <= '0;
      last_gnt_r <= IW'(R - 1);
      beat_cnt_r <= '0;
      pkt_done_r <= 1'b0;
    end else begin
      pkt_done_r <= last_beat_s;
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            gnt_r   <= next_gnt_s;
            state_r <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (last_beat_s) begin
            beat_cnt_r <= '0;
            last_gnt_r <= gnt_r;
            state_r    <= ST_IDLE;
          end else if (accept_s) begin
            beat_cnt_r <= beat_cnt_r + CW'(1);
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          beat_cnt_r <= '0;
        end
      endcase
    end
  end
endmodule
